// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl
//   Sequencer for a variable-decimation CIC decimator. Accepts power-of-2
//   decimation change requests, flushes the CIC (holds it in reset), loads
//   the new decimation, then discards the first STAGES output strobes while
//   the comb stages settle. Downstream sees only out_strobe, which is aligned
//   with valid CIC output data.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-low reset
//   cfg_wr         one-cycle request strobe
//   cfg_log2       requested log2 decimation (sampled when cfg_wr=1)
//   cfg_busy       high while flushing or settling
//   cfg_err        one-cycle pulse per rejected request
//   cur_log2       log2 decimation currently driven to the CIC
//   cic_reset      active-high reset to the CIC
//   cic_decim      decimation value to the CIC (1 << cur_log2)
//   cic_out_strobe CIC output strobe
//   out_strobe     gated, registered output-valid strobe
module cic_decim_ctrl #(
  parameter int unsigned MAX_LOG2     = 11,
  parameter int unsigned DEFAULT_LOG2 = 0,
  parameter int unsigned STAGES       = 5,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned MD           = 18
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cfg_wr,
  input  logic [3:0]    cfg_log2,
  output logic          cfg_busy,
  output logic          cfg_err,
  output logic [3:0]    cur_log2,
  output logic          cic_reset,
  output logic [MD-1:0] cic_decim,
  input  logic          cic_out_strobe,
  output logic          out_strobe
);

  localparam int unsigned FCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam int unsigned SCW = (STAGES < 2) ? 1 : $clog2(STAGES);

  localparam logic [3:0]     MAX4        = 4'(MAX_LOG2);
  localparam logic [3:0]     DEF4        = 4'(DEFAULT_LOG2);
  localparam logic [FCW-1:0] FLUSH_LOAD  = FCW'(RST_CYCLES);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(STAGES - 1);

  typedef enum logic [1:0] {
    FLUSH,
    SETTLE,
    RUN
  } state_t;

  state_t         state;
  logic [FCW-1:0] flush_cnt;
  logic [SCW-1:0] settle_cnt;
  logic           pend_vld;
  logic [3:0]     pend_log2;

  logic           req_bad;
  logic           req_ok;
  logic           nxt_pend_vld;
  logic [3:0]     nxt_pend_log2;
  logic           settle_last;

  function automatic logic [MD-1:0] decim_of(input logic [3:0] l2);
    logic [MD-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << l2;
  endfunction

  // A request arriving on the final settle strobe is treated as the newest
  // pending value, so the end-of-settle decision uses the merged view.
  always_comb begin
    req_bad       = cfg_wr && (cfg_log2 > MAX4);
    req_ok        = cfg_wr && !req_bad;
    nxt_pend_vld  = req_ok ? 1'b1 : pend_vld;
    nxt_pend_log2 = req_ok ? cfg_log2 : pend_log2;
    settle_last   = (settle_cnt == SETTLE_LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= FLUSH;
      flush_cnt  <= FLUSH_LOAD;
      settle_cnt <= '0;
      pend_vld   <= 1'b0;
      pend_log2  <= '0;
      cur_log2   <= DEF4;
      cic_decim  <= decim_of(DEF4);
      cic_reset  <= 1'b1;
      cfg_busy   <= 1'b1;
      cfg_err    <= 1'b0;
      out_strobe <= 1'b0;
    end else begin
      cfg_err <= req_bad;
      // Strobes seen in RUN are forwarded even when a change is accepted in
      // the same cycle: that sample belongs to the old, valid configuration.
      out_strobe <= (state == RUN) && cic_out_strobe;

      unique case (state)
        FLUSH: begin
          pend_vld  <= nxt_pend_vld;
          pend_log2 <= nxt_pend_log2;
          if (flush_cnt == FCW'(1)) begin
            state      <= SETTLE;
            cic_reset  <= 1'b0;
            settle_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - FCW'(1);
          end
        end

        SETTLE: begin
          pend_vld  <= nxt_pend_vld;
          pend_log2 <= nxt_pend_log2;
          if (cic_out_strobe) begin
            if (settle_last) begin
              pend_vld <= 1'b0;
              if (nxt_pend_vld && (nxt_pend_log2 != cur_log2)) begin
                state     <= FLUSH;
                flush_cnt <= FLUSH_LOAD;
                cur_log2  <= nxt_pend_log2;
                cic_decim <= decim_of(nxt_pend_log2);
                cic_reset <= 1'b1;
              end else begin
                state    <= RUN;
                cfg_busy <= 1'b0;
              end
            end else begin
              settle_cnt <= settle_cnt + SCW'(1);
            end
          end
        end

        RUN: begin
          if (req_ok && (cfg_log2 != cur_log2)) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
            cur_log2  <= cfg_log2;
            cic_decim <= decim_of(cfg_log2);
            cic_reset <= 1'b1;
            cfg_busy  <= 1'b1;
          end
        end

        default: begin
          state     <= FLUSH;
          flush_cnt <= FLUSH_LOAD;
          cic_reset <= 1'b1;
          cfg_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencer for a variable-decimation CIC decimator on the receiver/waterfall path. It accepts power-of-2 decimation change requests from the CPU register interface and applies them safely. Each change holds the CIC in reset to flush its integrators and loads the new decimation. It then discards the first STAGES output samples, which are invalid during comb-stage settling. Downstream logic sees only a gated `out_strobe` that is aligned to valid CIC output data.

## Interface
Parameters:
- `MAX_LOG2`, 11: largest accepted log2 decimation (11 = R 2048); must match the CIC's GROWTH sizing.
- `DEFAULT_LOG2`, 0: log2 decimation applied after reset.
- `STAGES`, 5: CIC stage count; number of output strobes discarded after each change.
- `RST_CYCLES`, 4: cycles `cic_reset` is held per flush (≥1).
- `MD`, 18: width of decimation bus to CIC.

Ports:
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `cfg_wr`  in  1  one-cycle request strobe.
- `cfg_log2`  in  4  requested log2 decimation, sampled when `cfg_wr`=1.
- `cfg_busy`  out  1  high while flushing or settling.
- `cfg_err`  out  1  one-cycle pulse on rejected request.
- `cur_log2`  out  4  log2 decimation currently driven to CIC.
- `cic_reset`  out  1  active-high reset to CIC.
- `cic_decim`  out  MD  decimation value to CIC (`1 << cur_log2`).
- `cic_out_strobe`  in  1  CIC output strobe.
- `out_strobe`  out  1  gated, registered output-valid strobe.

## Operation
- FSM states: FLUSH, SETTLE, RUN.
- **FLUSH:** `cic_reset`=1. A down-counter loaded with RST_CYCLES decrements each cycle. At zero, go to SETTLE and clear the settle counter. `cic_out_strobe` is ignored.
- **SETTLE:** `cic_reset`=0. Count `cic_out_strobe` pulses without forwarding them.
  - On the STAGES-th pulse, go to FLUSH if a request is pending, else RUN.
  - In both cases the STAGES-th pulse is itself suppressed.
- **RUN:** `cic_reset`=0, `cfg_busy`=0. Each `cic_out_strobe` produces `out_strobe` one cycle later.
- Request handling when `cfg_wr`=1:
  - `cfg_log2` > MAX_LOG2: `cfg_err` pulses next cycle; no state, pending or decimation change.
  - Valid request in RUN, equal to `cur_log2`: ignored; no flush, no error.
  - Valid request in RUN, different from `cur_log2`: `cur_log2`/`cic_decim` update and FSM enters FLUSH next cycle.
  - Valid request in FLUSH/SETTLE: stored in a one-deep pending register; a later request overwrites it (last wins). The pending value is applied at the end of SETTLE, not mid-sequence. If it equals `cur_log2`, it is dropped and the FSM enters RUN.
- `cic_decim` = zero-extended `1 << cur_log2`. It changes only on entry to FLUSH, never in SETTLE/RUN.
- **Reset** (`reset`=0, any state, including mid-sequence):
  - Pending is cleared and `cur_log2` = DEFAULT_LOG2.
  - FSM enters FLUSH with counter = RST_CYCLES.
  - A `cfg_wr` coincident with reset is dropped.
- If the CIC stops strobing (no input), SETTLE waits indefinitely; `cfg_busy` stays 1. This is by design.

## Timing
- Reset values while `reset`=0:
  - `cic_reset`=1, `cfg_busy`=1, `cfg_err`=0, `out_strobe`=0.
  - `cur_log2`=DEFAULT_LOG2, `cic_decim`=1<<DEFAULT_LOG2.
- First cycle after reset release: FLUSH continues; `cic_reset` stays 1 for RST_CYCLES cycles after release.
- Valid change request at cycle t in RUN:
  - t+1: `cic_decim` new value, `cic_reset`=1, `cfg_busy`=1.
  - t+1 … t+RST_CYCLES: `cic_reset`=1.
- A request is accepted in RUN in the same cycle that a `cic_out_strobe` arrives. That strobe is still forwarded as `out_strobe` at t+1, because it belongs to the old configuration and its data is valid.
- `out_strobe` latency is 1 cycle from `cic_out_strobe`. This matches the CIC's registered data output, so data is valid when `out_strobe`=1.
- `cfg_busy` falls in the same cycle the FSM enters RUN.
- `cfg_err` is exactly 1 cycle wide per rejected request; back-to-back rejects give back-to-back pulses.

## Test plan
- **Reset and settle:** release reset with DEFAULT_LOG2=0, RST_CYCLES=4, STAGES=5, strobe every 3 cycles.
  - `cic_reset` high 4 cycles, `cic_decim`=1.
  - First 5 strobes dropped, 6th gives `out_strobe` 1 cycle later, `cfg_busy` falls on the 5th.
- **Valid change:** in RUN, `cfg_wr` with `cfg_log2`=8.
  - Next cycle `cic_decim`=256, `cic_reset`=1 for 4 cycles.
  - Exactly 5 strobes suppressed, then forwarding resumes.
- **Invalid request:** `cfg_log2`=12 with MAX_LOG2=11 → single `cfg_err` pulse; `cic_decim`, `cur_log2` and `out_strobe` flow unchanged.
- **Requests during a sequence:** writes of 3 then 6 during SETTLE → after 5th strobe, a second FLUSH with `cic_decim`=64; value 3 is never applied.
- **Same value:** request equal to `cur_log2` in RUN → no `cic_reset`, no busy, no dropped strobes.
- **Reset mid-SETTLE:** assert `reset` after 2 settle strobes → FLUSH restarts, `cic_decim`=1<<DEFAULT_LOG2, pending cleared, full 5-strobe settle repeated.
